// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8-to-1 selector scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Per-channel dwell counter: counts 0..DWELL-1 while enabled and flags the final cycle.
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last_cycle
);

  localparam int unsigned          CNT_W    = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last_cycle = (cnt == CNT_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the 8-to-1 selector through channels 0..7 and assembles the samples into a byte.
// Optional build macro: MUX_SCAN_CONTINUOUS_EN (free-running rescan, start ignored).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mask,
  input  logic       mux_q,
  output logic       mux_s_n,
  output logic [2:0] mux_a,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch, ch_nxt;
  logic [NUM_CH-1:0] mask_r, mask_nxt;
  logic [NUM_CH-1:0] shadow, shadow_nxt;
  logic              go;
  logic              tmr_last;
  logic              chan_last;
  logic              mux_s_n_nxt, busy_nxt, done_nxt;
  logic [CH_W-1:0]   mux_a_nxt;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state != SCAN || chan_last),
    .en        (state == SCAN),
    .last_cycle(tmr_last)
  );

  // A masked channel always finishes in its single cycle.
  assign chan_last = (state == SCAN) && (mask_r[ch] || tmr_last);

`ifdef MUX_SCAN_CONTINUOUS_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch     <= '0;
      mask_r <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nxt;
      ch     <= ch_nxt;
      mask_r <= mask_nxt;
      shadow <= shadow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    mask_nxt   = mask_r;
    shadow_nxt = shadow;
    case (state)
      IDLE: begin
        if (go) begin
          mask_nxt   = mask;
          shadow_nxt = '0;
          ch_nxt     = '0;
          state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (chan_last) begin
          shadow_nxt[ch] = mask_r[ch] ? 1'b0 : mux_q;
          if (ch == LAST_CH) begin
            state_nxt = DONE;
          end else begin
            ch_nxt = ch + 1'b1;
          end
        end
      end
      DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        mask_nxt   = mask;
        shadow_nxt = '0;
        ch_nxt     = '0;
        state_nxt  = SCAN;
`else
        state_nxt  = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered ports line up with it.
  always_comb begin
    busy_nxt    = (state_nxt == SCAN);
    done_nxt    = (state_nxt == DONE);
    mux_a_nxt   = busy_nxt ? ch_nxt : '0;
    mux_s_n_nxt = !(busy_nxt && !mask_nxt[ch_nxt]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_s_n <= 1'b1;
      mux_a   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= '0;
    end else begin
      mux_s_n <= mux_s_n_nxt;
      mux_a   <= mux_a_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      if (done_nxt) begin
        data <= shadow_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; three instances (DWELL=4, 1, 2) with model selectors.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start4, q4, s_n4, busy4, done4;
  logic [7:0] mask4, data4, d4;
  logic [2:0] a4;

  logic       start1, q1, s_n1, busy1, done1;
  logic [7:0] mask1, data1, d1;
  logic [2:0] a1;

  logic       start2, q2, s_n2, busy2, done2;
  logic [7:0] mask2, data2, d2;
  logic [2:0] a2;

  int n_total = 0;
  int n_bad   = 0;

  assign q4 = s_n4 ? 1'b0 : d4[a4];
  assign q1 = s_n1 ? 1'b0 : d1[a1];
  assign q2 = s_n2 ? 1'b0 : d2[a2];

  mux_scan_ctrl #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mask(mask4), .mux_q(q4),
    .mux_s_n(s_n4), .mux_a(a4), .busy(busy4), .done(done4), .data(data4)
  );

  mux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mask(mask1), .mux_q(q1),
    .mux_s_n(s_n1), .mux_a(a1), .busy(busy1), .done(done1), .data(data1)
  );

  mux_scan_ctrl #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mask(mask2), .mux_q(q2),
    .mux_s_n(s_n2), .mux_a(a2), .busy(busy2), .done(done2), .data(data2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full DWELL=4 unmasked scan; optional start re-pulses in cycles 5 and 33.
  task automatic scan4(input logic [7:0] d, input logic [7:0] prev, input logic repulse);
    d4     = d;
    mask4  = 8'h00;
    start4 = 1'b1;
    step();
    for (int c = 1; c <= 34; c++) begin
      start4 = repulse && (c == 5 || c == 33);
      chk("scan4_busy", busy4, c <= 32);
      chk("scan4_done", done4, c == 33);
      chk("scan4_mux_a", a4, (c <= 32) ? (c - 1) / 4 : 0);
      chk("scan4_mux_s_n", s_n4, (c <= 32) ? 0 : 1);
      chk("scan4_data", data4, (c >= 33) ? d : prev);
      step();
    end
    start4 = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b0; mask4 = 8'h00; d4 = 8'h00;
    start1 = 1'b0; mask1 = 8'h00; d1 = 8'h00;
    start2 = 1'b0; mask2 = 8'h00; d2 = 8'h3C;
    step();
    step();
    chk("rst_mux_s_n", s_n4, 1);
    chk("rst_outs", {a4, busy4, done4, data4}, 0);

`ifdef MUX_SCAN_CONTINUOUS_EN
    rst_n = 1'b1;
    step();
    for (int c = 1; c <= 36; c++) begin
      int p;
      p = (c - 1) % 17;
      if (c == 9) d2 = 8'hC3;
      chk("cont_done", done2, c == 17 || c == 34);
      chk("cont_busy", busy2, p != 16);
      chk("cont_mux_a", a2, (p == 16) ? 0 : p / 2);
      chk("cont_mux_s_n", s_n2, p == 16);
      chk("cont_data", data2, (c < 17) ? 8'h00 : (c < 34) ? 8'hCC : 8'hC3);
      step();
    end
`else
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      chk("idle_outs4", {s_n4, a4, busy4, done4, data4}, {1'b1, 13'd0});
      chk("idle_outs1", {s_n1, a1, busy1, done1, data1}, {1'b1, 13'd0});
      step();
    end

    scan4(8'hA5, 8'h00, 1'b0);

    d1     = 8'hFF;
    mask1  = 8'h0F;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    mask1  = 8'hF0;
    for (int c = 1; c <= 10; c++) begin
      chk("scan1_busy", busy1, c <= 8);
      chk("scan1_done", done1, c == 9);
      chk("scan1_mux_a", a1, (c <= 8) ? c - 1 : 0);
      chk("scan1_mux_s_n", s_n1, (c <= 8) ? (c <= 4) : 1);
      chk("scan1_data", data1, (c >= 9) ? 8'hF0 : 8'h00);
      step();
    end

    scan4(8'h3C, 8'hA5, 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("post_idle", {busy4, done4, s_n4}, 3'b001);
      chk("post_data", data4, 8'h3C);
      step();
    end
    scan4(8'h5A, 8'h3C, 1'b0);

    d4     = 8'h77;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c < 15; c++) step();
    chk("mid_busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {s_n4, a4, busy4, done4, data4}, {1'b1, 13'd0});
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk("post_rst_outs", {s_n4, a4, busy4, done4, data4}, {1'b1, 13'd0});
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
